// File: rtl/ctrl_word_pipe.sv
// ctrl_word_pipe
//   Consumer side of decode. Takes one rv32i control word per cycle from the
//   ID-stage decoder. Carries it, together with rd and a valid bit, through the
//   EX, MEM and WB pipeline registers. Load-use hazards and data-memory stalls
//   hold ID. Branch flushes squash EX. The block produces the gated regfile
//   write enable and a saturating bubble counter.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   id_valid/id_ctrl/id_rd      instruction offered by ID
//   id_rs1, id_rs2              ID source registers (hazard compare)
//   ex_flush                    taken branch/jump resolved in EX
//   dmem_resp                   data-memory response for the MEM-stage access
//   {ex,mem,wb}_{valid,ctrl,rd} pipeline stage registers
//   id_stall                    hold PC and IF/ID
//   wb_load_regfile             gated regfile write enable (never for x0)
//   bubble_count                bubbles injected since reset, saturating

package ctrl_word_pipe_pkg;

    localparam logic [6:0] op_lui   = 7'b0110111;
    localparam logic [6:0] op_auipc = 7'b0010111;
    localparam logic [6:0] op_jal   = 7'b1101111;
    localparam logic [6:0] op_jalr  = 7'b1100111;
    localparam logic [6:0] op_br    = 7'b1100011;
    localparam logic [6:0] op_load  = 7'b0000011;
    localparam logic [6:0] op_store = 7'b0100011;
    localparam logic [6:0] op_imm   = 7'b0010011;
    localparam logic [6:0] op_reg   = 7'b0110011;
    localparam logic [6:0] op_csr   = 7'b1110011;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] aluop;
        logic [2:0] cmpop;
        logic       alumux1_sel;
        logic [2:0] alumux2_sel;
        logic [3:0] regfilemux_sel;
        logic       load_regfile;
        logic       mem_read;
        logic       mem_write;
        logic [3:0] mem_byte_enable;
    } rv32i_control_word;

    typedef struct packed {
        logic              valid;
        rv32i_control_word ctrl;
        logic [4:0]        rd;
    } pipe_stage_t;

endpackage

module ctrl_word_pipe
    import ctrl_word_pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  rv32i_control_word id_ctrl,
    input  logic [4:0]        id_rd,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              ex_flush,
    input  logic              dmem_resp,
    output logic              ex_valid,
    output rv32i_control_word ex_ctrl,
    output logic [4:0]        ex_rd,
    output logic              mem_valid,
    output rv32i_control_word mem_ctrl,
    output logic [4:0]        mem_rd,
    output logic              wb_valid,
    output rv32i_control_word wb_ctrl,
    output logic [4:0]        wb_rd,
    output logic              id_stall,
    output logic              wb_load_regfile,
    output logic [CNT_W-1:0]  bubble_count
);

    pipe_stage_t      ex_q, ex_d;
    pipe_stage_t      mem_q, mem_d;
    pipe_stage_t      wb_q, wb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic mem_stall;
    logic hazard;
    logic cnt_inc;

    assign mem_stall = mem_q.valid
                     & ((mem_q.ctrl.opcode == op_load) | (mem_q.ctrl.opcode == op_store))
                     & ~dmem_resp;

    assign hazard = id_valid & ex_q.valid & (ex_q.ctrl.opcode == op_load)
                  & (ex_q.rd != 5'd0)
                  & ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));

    // A flush consumes the ID slot by squashing EX. It therefore overrides
    // the hazard stall. A memory stall freezes everything, including the flush.
    assign id_stall = mem_stall | (hazard & ~ex_flush);

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (mem_stall) begin
            wb_d = '0;
        end else begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (ex_flush || hazard || !id_valid) begin
                ex_d = '0;
            end else begin
                ex_d.valid = 1'b1;
                ex_d.ctrl  = id_ctrl;
                ex_d.rd    = id_rd;
            end
        end
    end

    // Each of mem_stall, flush or hazard injects exactly one bubble per edge.
    assign cnt_inc = mem_stall | ex_flush | hazard;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_valid  = ex_q.valid;
    assign ex_ctrl   = ex_q.ctrl;
    assign ex_rd     = ex_q.rd;
    assign mem_valid = mem_q.valid;
    assign mem_ctrl  = mem_q.ctrl;
    assign mem_rd    = mem_q.rd;
    assign wb_valid  = wb_q.valid;
    assign wb_ctrl   = wb_q.ctrl;
    assign wb_rd     = wb_q.rd;

    assign wb_load_regfile = wb_q.valid & wb_q.ctrl.load_regfile & (wb_q.rd != 5'd0);
    assign bubble_count    = cnt_q;

endmodule
